// File: rtl/mem_access_sequencer_if.sv
// Bundle of MEM-stage control, data-memory handshake and pipeline stall/flush signals.
// master: pipeline/memory side that drives requests and Ready; slave: the sequencer.
interface mem_access_sequencer_if;
  logic M_MemRead;
  logic M_MemWrite;
  logic M_Exception;
  logic DataMem_Ready;
  logic DataMem_Read;
  logic DataMem_Write;
  logic M_Stall;
  logic WB_Stall;
  logic M_Flush;
  logic M_BusError;

  modport master (
    output M_MemRead, M_MemWrite, M_Exception, DataMem_Ready,
    input  DataMem_Read, DataMem_Write, M_Stall, WB_Stall, M_Flush, M_BusError
  );

  modport slave (
    input  M_MemRead, M_MemWrite, M_Exception, DataMem_Ready,
    output DataMem_Read, DataMem_Write, M_Stall, WB_Stall, M_Flush, M_BusError
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// MEM-stage data-memory access sequencer driving strobes and MEM/WB stall/flush; MEMSEQ_TIMEOUT_EN adds a bus timeout.
// Latency: outputs are combinational from state and inputs; zero-wait access when Ready arrives with the request.
// Backpressure: holds M_Stall/WB_Stall while memory is not ready; a timeout ends the access with a flush and bus error.
module mem_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic                   clock,
  input logic                   reset,
  mem_access_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT
`ifdef MEMSEQ_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  state_t state;
  state_t state_nxt;

  logic req;
  logic rd_dat;
  logic wr_dat;
  logic stall;
  logic flush;
  logic bus_err;
  logic timeout;

  assign req = bus.M_MemRead | bus.M_MemWrite;

`ifdef MEMSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Counter restarts every IDLE cycle, so it is zero on entry to WAIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
    end else if (state == S_WAIT && !bus.DataMem_Ready && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (state == S_WAIT) && !bus.DataMem_Ready && (cnt == CNT_LAST);
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == CNT_W);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!bus.M_Exception && req && !bus.DataMem_Ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.DataMem_Ready) begin
          state_nxt = S_IDLE;
`ifdef MEMSEQ_TIMEOUT_EN
        end else if (timeout) begin
          state_nxt = S_ERROR;
`endif
        end
      end
`ifdef MEMSEQ_TIMEOUT_EN
      S_ERROR: state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Store wins when both strobes are requested; reset low forces every output to 0.
  always_comb begin
    rd_dat  = 1'b0;
    wr_dat  = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    bus_err = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE: begin
          if (bus.M_Exception) begin
            flush = 1'b1;
          end else if (req) begin
            wr_dat = bus.M_MemWrite;
            rd_dat = bus.M_MemRead & ~bus.M_MemWrite;
            stall  = ~bus.DataMem_Ready;
          end
        end
        S_WAIT: begin
          wr_dat = bus.M_MemWrite;
          rd_dat = bus.M_MemRead & ~bus.M_MemWrite;
          stall  = ~bus.DataMem_Ready;
        end
`ifdef MEMSEQ_TIMEOUT_EN
        S_ERROR: begin
          flush   = 1'b1;
          bus_err = 1'b1;
        end
`endif
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  assign bus.DataMem_Read  = rd_dat;
  assign bus.DataMem_Write = wr_dat;
  assign bus.M_Stall       = stall;
  assign bus.WB_Stall      = stall;
  assign bus.M_Flush       = flush;
  assign bus.M_BusError    = bus_err;

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Controller that sequences data-memory accesses for the MEM stage and drives the stall/flush controls of the MEM and MEM/WB pipeline registers. It issues read/write strobes toward data memory and holds MEM and WB while memory is not ready. It converts MEM-stage exceptions and optional bus timeouts into a MEM flush. It sits between the EX/MEM register outputs, the data-memory port and the MEM/WB register's stall/flush inputs.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before a bus error. Legal range is 2..2^CNT_W.
- CNT_W, 8: width of the timeout counter.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- M_MemRead  in  1  MEM-stage instruction is a load.
- M_MemWrite  in  1  MEM-stage instruction is a store.
- M_Exception  in  1  exception detected for the MEM-stage instruction.
- DataMem_Ready  in  1  memory completes the current access this cycle.
- DataMem_Read  out  1  read strobe to data memory.
- DataMem_Write  out  1  write strobe to data memory.
- M_Stall  out  1  holds the MEM stage; masks control signals into WB.
- WB_Stall  out  1  holds the MEM/WB register; always equal to M_Stall.
- M_Flush  out  1  clears control signals into WB.
- M_BusError  out  1  one-cycle pulse when an access times out.

## Operation
- States: IDLE, WAIT, ERROR. The state encoding is implementation choice.
- All outputs are combinational from state and inputs. While reset is low, all outputs are forced to 0.
- **Request definition:** req = M_MemRead | M_MemWrite. If both are set, the access is a write and DataMem_Read stays 0.
- **IDLE with M_Exception=1:**
  - No strobe, M_Flush=1, M_Stall=0.
  - Stay in IDLE.
  - The exception has priority over req.
- **IDLE with req=1 and no exception:**
  - Assert the matching strobe.
  - If DataMem_Ready=1 in the same cycle, the access completes with zero wait: M_Stall=0, stay in IDLE.
  - Otherwise M_Stall=1, clear the counter, and go to WAIT.
- **IDLE with req=0:** all outputs 0. DataMem_Ready is ignored.
- **WAIT:**
  - Hold the strobe (inputs are frozen by the stall) and keep M_Stall=1.
  - On DataMem_Ready=1: M_Stall=0 that cycle, so MEM/WB captures the data. Go to IDLE.
  - Otherwise increment the counter.
  - M_Exception is ignored in WAIT; it is serviced in IDLE after completion. An in-flight access is never abandoned by an exception.
- **Timeout:** in WAIT, if the counter equals TIMEOUT_CYCLES-1 and Ready=0, the next state is ERROR. Ready on that same cycle still completes the access normally.
- **ERROR** (lasts exactly one cycle):
  - Strobes=0, M_Stall=0, M_Flush=1, M_BusError=1.
  - Next state is IDLE. A Ready arriving in ERROR is ignored.
- The counter saturates and never wraps.

## Timing
- **Reset:** state=IDLE, counter=0, all outputs 0 asynchronously on reset falling. Release is synchronous to clock.
- **Reset mid-access:** the access is abandoned immediately and the strobes drop in the same cycle.
- **Zero-wait access:** 0 stall cycles.
- **Access with Ready arriving N cycles after the request cycle:** M_Stall is high for N consecutive cycles. WB captures on the edge ending the Ready cycle.
- **Timed-out access:** M_Stall is high for 1+TIMEOUT_CYCLES cycles, followed by a single ERROR cycle.
- **Back-to-back accesses:** a new request is accepted in the IDLE cycle directly after completion, with no dead cycle.
- **WB_Stall:** identical to M_Stall in every cycle.

## Configuration
- **MEMSEQ_TIMEOUT_EN defined:**
  - Counter and ERROR state are present, with timeout behaviour as above.
- **MEMSEQ_TIMEOUT_EN undefined:**
  - No counter and no ERROR state; WAIT persists until DataMem_Ready.
  - M_BusError is tied to 0.
  - The TIMEOUT_CYCLES and CNT_W parameters are unused.

## Test plan
- **Reset:** hold reset=0 with M_MemRead=1 and DataMem_Ready=0 → all outputs 0. Release reset → the next cycle shows DataMem_Read=1 and M_Stall=1.
- **Zero-wait load:** M_MemRead=1 with DataMem_Ready=1 in the same cycle → DataMem_Read=1, M_Stall=WB_Stall=0. State stays IDLE.
- **Store with 3 wait cycles:** M_MemWrite=1, Ready asserted on the 4th cycle → M_Stall high for exactly 3 cycles and DataMem_Write high for 4 cycles. Read+write together yields DataMem_Read=0.
- **Exception:** M_Exception=1 with M_MemRead=1 in IDLE → M_Flush=1 with no strobe. Exception raised during WAIT → ignored until Ready, then flush on the next IDLE cycle.
- **Timeout** (TIMEOUT_CYCLES=4, macro on, Ready never asserted) → M_Stall high for 5 cycles, then one cycle of M_Flush=1 and M_BusError=1, then IDLE. A repeat with Ready on the 4th WAIT cycle completes with no error.
- **Macro off:** Ready withheld for 300 cycles → M_Stall held for 300 cycles and M_BusError stays 0. Ready then completes the access.
